// File: rtl/argmax_classifier.sv
// argmax_classifier: scans each GSRAM row and emits (row, class, max) per row.
// Optional runner-up/margin outputs are enabled with `define ARGMAX_TOP2_EN.
module argmax_classifier #(
    parameter int unsigned ROWS   = 10,
    parameter int unsigned COLS   = 10,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              gsram_rd_en,
    output logic [IDX_W-1:0]  gsram_addr_row,
    output logic [IDX_W-1:0]  gsram_addr_col,
    input  logic [DATA_W-1:0] gsram_rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_row,
    output logic [IDX_W-1:0]  out_class,
    output logic [DATA_W-1:0] out_max,
`ifdef ARGMAX_TOP2_EN
    output logic [IDX_W-1:0]  out_class2,
    output logic [DATA_W:0]   out_margin,
`endif
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_READ  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_EMIT  = 3'd3;
    localparam logic [2:0] S_FIN   = 3'd4;

    localparam logic signed [DATA_W-1:0] MAX_INIT = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(ROWS - 1);
    localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(COLS - 1);

    logic [2:0]               state_q, state_d;
    logic [IDX_W-1:0]         row_q, row_d;
    logic [IDX_W-1:0]         col_q, col_d;
    logic signed [DATA_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]         cls_q, cls_d;
    logic                     cmp_vld_q, cmp_vld_d;
    logic [IDX_W-1:0]         cmp_col_q, cmp_col_d;
    logic                     rd_en_q, rd_en_d;
    logic [IDX_W-1:0]         addr_row_q, addr_row_d;
    logic [IDX_W-1:0]         addr_col_q, addr_col_d;
    logic                     out_valid_q, out_valid_d;
    logic [IDX_W-1:0]         out_row_q, out_row_d;
    logic [IDX_W-1:0]         out_class_q, out_class_d;
    logic [DATA_W-1:0]        out_max_q, out_max_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
`ifdef ARGMAX_TOP2_EN
    logic signed [DATA_W-1:0] sec_q, sec_d;
    logic [IDX_W-1:0]         cls2_q, cls2_d;
    logic [IDX_W-1:0]         out_class2_q, out_class2_d;
    logic [DATA_W:0]          out_margin_q, out_margin_d;
`endif

    logic signed [DATA_W-1:0] rd_s;
    assign rd_s = $signed(gsram_rd_data);

    // Next-state: fold returning read data into the running max, then advance the FSM
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        max_d       = max_q;
        cls_d       = cls_q;
        cmp_vld_d   = 1'b0;
        cmp_col_d   = cmp_col_q;
        rd_en_d     = 1'b0;
        addr_row_d  = '0;
        addr_col_d  = '0;
        out_valid_d = out_valid_q;
        out_row_d   = out_row_q;
        out_class_d = out_class_q;
        out_max_d   = out_max_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
`ifdef ARGMAX_TOP2_EN
        sec_d        = sec_q;
        cls2_d       = cls2_q;
        out_class2_d = out_class2_q;
        out_margin_d = out_margin_q;
`endif

        // Column 0 seeds the row; later columns replace only on strictly greater
        if (cmp_vld_q) begin
            if (cmp_col_q == '0) begin
                max_d = rd_s;
                cls_d = '0;
`ifdef ARGMAX_TOP2_EN
                sec_d  = MAX_INIT;
                cls2_d = '0;
`endif
            end else if (rd_s > max_q) begin
`ifdef ARGMAX_TOP2_EN
                sec_d  = max_q;
                cls2_d = cls_q;
`endif
                max_d = rd_s;
                cls_d = cmp_col_q;
            end
`ifdef ARGMAX_TOP2_EN
            else if ((cmp_col_q == IDX_W'(1)) || (rd_s > sec_q)) begin
                sec_d  = rd_s;
                cls2_d = cmp_col_q;
            end
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_READ;
                    row_d   = '0;
                    col_d   = '0;
                    max_d   = MAX_INIT;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            S_READ: begin
                cmp_vld_d = 1'b1;
                cmp_col_d = col_q;
                if (col_q == LAST_COL) begin
                    state_d = S_DRAIN;
                    col_d   = '0;
                end else begin
                    col_d      = col_q + IDX_W'(1);
                    rd_en_d    = 1'b1;
                    addr_row_d = row_q;
                    addr_col_d = col_q + IDX_W'(1);
                end
            end
            S_DRAIN: begin
                state_d     = S_EMIT;
                out_valid_d = 1'b1;
                out_row_d   = row_q;
                out_class_d = cls_d;
                out_max_d   = max_d;
`ifdef ARGMAX_TOP2_EN
                out_class2_d = cls2_d;
                out_margin_d = {max_d[DATA_W-1], max_d} - {sec_d[DATA_W-1], sec_d};
`endif
            end
            S_EMIT: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    out_row_d   = '0;
                    out_class_d = '0;
                    out_max_d   = '0;
`ifdef ARGMAX_TOP2_EN
                    out_class2_d = '0;
                    out_margin_d = '0;
`endif
                    if (row_q == LAST_ROW) begin
                        state_d = S_FIN;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d    = S_READ;
                        row_d      = row_q + IDX_W'(1);
                        col_d      = '0;
                        max_d      = MAX_INIT;
                        rd_en_d    = 1'b1;
                        addr_row_d = row_q + IDX_W'(1);
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers, synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            max_q       <= MAX_INIT;
            cls_q       <= '0;
            cmp_vld_q   <= 1'b0;
            cmp_col_q   <= '0;
            rd_en_q     <= 1'b0;
            addr_row_q  <= '0;
            addr_col_q  <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_class_q <= '0;
            out_max_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef ARGMAX_TOP2_EN
            sec_q        <= MAX_INIT;
            cls2_q       <= '0;
            out_class2_q <= '0;
            out_margin_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            max_q       <= max_d;
            cls_q       <= cls_d;
            cmp_vld_q   <= cmp_vld_d;
            cmp_col_q   <= cmp_col_d;
            rd_en_q     <= rd_en_d;
            addr_row_q  <= addr_row_d;
            addr_col_q  <= addr_col_d;
            out_valid_q <= out_valid_d;
            out_row_q   <= out_row_d;
            out_class_q <= out_class_d;
            out_max_q   <= out_max_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
`ifdef ARGMAX_TOP2_EN
            sec_q        <= sec_d;
            cls2_q       <= cls2_d;
            out_class2_q <= out_class2_d;
            out_margin_q <= out_margin_d;
`endif
        end
    end

    assign gsram_rd_en    = rd_en_q;
    assign gsram_addr_row = addr_row_q;
    assign gsram_addr_col = addr_col_q;
    assign out_valid      = out_valid_q;
    assign out_row        = out_row_q;
    assign out_class      = out_class_q;
    assign out_max        = out_max_q;
    assign busy           = busy_q;
    assign done           = done_q;
`ifdef ARGMAX_TOP2_EN
    assign out_class2     = out_class2_q;
    assign out_margin     = out_margin_q;
`endif

endmodule
